// File: rtl/rf_wb_scoreboard.sv
// Register-file write-port arbiter (ALU vs. long-latency unit) with a busy scoreboard
// driving the decode hazard stall. Define RF_WB_STATS_EN to add stall/preemption counters.
module rf_wb_scoreboard #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  input  logic        iss_use_rs1,
  input  logic        iss_use_rs2,
  input  logic [4:0]  iss_rd,
  input  logic        iss_long,
  output logic        iss_stall,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        lng_valid,
  input  logic [4:0]  lng_rd,
  input  logic [31:0] lng_data,
  output logic        lng_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        sb_err
`ifdef RF_WB_STATS_EN
  ,
  output logic [31:0] stat_stall_cnt,
  output logic [31:0] stat_preempt_cnt
`endif
);

  localparam int unsigned NREG  = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned XLEN  = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

  logic [NREG-1:0]  busy;
  logic [CNT_W-1:0] cnt;
  logic             rf_long;

  logic             starve_hit;
  logic             alu_acc;
  logic             lng_acc;
  logic             wr_any;
  logic             sb_hit;
  logic             iss_go;
  logic [IDX_W-1:0] wr_rd;
  logic [XLEN-1:0]  wr_data;
  logic [NREG-1:0]  set_vec;
  logic [NREG-1:0]  clr_vec;
  logic [NREG-1:0]  busy_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Decode hazard: RAW on any used source, WAW on a nonzero destination.
  always_comb begin
    iss_stall = 1'b0;
    if (iss_valid) begin
      iss_stall = (iss_use_rs1 & busy[iss_rs1])
                | (iss_use_rs2 & busy[iss_rs2])
                | ((iss_rd != '0) & busy[iss_rd]);
    end
  end

  // Write-port arbitration: ALU wins unless the long result has waited too long.
  always_comb begin
    starve_hit = lng_valid & (cnt >= LIMIT);
    lng_ready  = rstn & (~alu_valid | starve_hit);
    alu_ready  = rstn & ~starve_hit;
    alu_acc    = alu_valid & alu_ready;
    lng_acc    = lng_valid & lng_ready;
    wr_any     = alu_acc | lng_acc;
    wr_rd      = lng_acc ? lng_rd : alu_rd;
    wr_data    = lng_acc ? lng_data : alu_data;
    sb_hit     = lng_acc & (lng_rd != '0) & ~busy[lng_rd];
  end

  // Busy bits clear as the long result is written; x0 is never tracked.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    iss_go  = iss_valid & ~iss_stall & iss_long & (iss_rd != '0);
    if (iss_go) begin
      set_vec[iss_rd] = 1'b1;
    end
    if (rf_we & rf_long) begin
      clr_vec[rf_rd] = 1'b1;
    end
    busy_nxt = ((busy & ~clr_vec) | set_vec) & ~NREG'(1);
  end

  // Starvation counter: counts consecutive refused cycles of a pending long result.
  always_comb begin
    cnt_nxt = cnt;
    if (lng_acc | ~lng_valid) begin
      cnt_nxt = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy    <= '0;
      cnt     <= '0;
      rf_we   <= 1'b0;
      rf_rd   <= '0;
      rf_data <= '0;
      rf_long <= 1'b0;
      sb_err  <= 1'b0;
    end else begin
      busy    <= busy_nxt;
      cnt     <= cnt_nxt;
      rf_we   <= wr_any & (wr_rd != '0);
      rf_long <= lng_acc;
      if (wr_any) begin
        rf_rd   <= wr_rd;
        rf_data <= wr_data;
      end
      if (sb_hit) begin
        sb_err <= 1'b1;
      end
    end
  end

`ifdef RF_WB_STATS_EN
  localparam logic [31:0] STAT_MAX = '1;

  // Saturating event counters for stall cycles and ALU preemptions.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_stall_cnt   <= '0;
      stat_preempt_cnt <= '0;
    end else begin
      if (iss_stall && (stat_stall_cnt != STAT_MAX)) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
      if (starve_hit && alu_valid && (stat_preempt_cnt != STAT_MAX)) begin
        stat_preempt_cnt <= stat_preempt_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Bench for rf_wb_scoreboard: directed vector table, a starvation sequence, and
// randomized traffic checked against a queue-free behavioural model.
module tb_rf_wb_scoreboard;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        iss_valid, iss_use_rs1, iss_use_rs2, iss_long, iss_stall;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        alu_valid, alu_ready, lng_valid, lng_ready;
  logic [4:0]  alu_rd, lng_rd, rf_rd;
  logic [31:0] alu_data, lng_data, rf_data;
  logic        rf_we, sb_err;
`ifdef RF_WB_STATS_EN
  logic [31:0] stat_stall_cnt, stat_preempt_cnt;
`endif

  always #5 clk = ~clk;

  rf_wb_scoreboard #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rstn(rstn),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2),
    .iss_rd(iss_rd), .iss_long(iss_long), .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lng_valid(lng_valid), .lng_rd(lng_rd), .lng_data(lng_data), .lng_ready(lng_ready),
`ifdef RF_WB_STATS_EN
    .stat_stall_cnt(stat_stall_cnt), .stat_preempt_cnt(stat_preempt_cnt),
`endif
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .sb_err(sb_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int rstn, iss, use1, rs1, rd, lng;
    int av, ard; logic [31:0] adata;
    int lv, lrd; logic [31:0] ldata;
    int e_stall, e_ar, e_lr, e_we, e_rd; logic [31:0] e_data; int e_err;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  task automatic apply(input vec_t v);
    rstn        = v.rstn[0];
    iss_valid   = v.iss[0];
    iss_use_rs1 = v.use1[0];
    iss_use_rs2 = 1'b0;
    iss_rs1     = 5'(v.rs1);
    iss_rs2     = 5'd0;
    iss_rd      = 5'(v.rd);
    iss_long    = v.lng[0];
    alu_valid   = v.av[0];
    alu_rd      = 5'(v.ard);
    alu_data    = v.adata;
    lng_valid   = v.lv[0];
    lng_rd      = 5'(v.lrd);
    lng_data    = v.ldata;
  endtask

  // Behavioural reference state
  bit          m_busy[32];
  int          m_wait;
  bit          m_we, m_tag, m_err;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bit a_pend, l_pend;
    logic [4:0]  a_rd, l_rd;
    logic [31:0] a_dat, l_dat;

    vecs[0]  = '{0,0,0,0,0,0, 0,0,0, 0,0,0,            0,0,0, 0,0,0,0};
    vecs[1]  = '{0,0,0,0,0,0, 0,0,0, 0,0,0,            0,0,0, 0,0,0,0};
    vecs[2]  = '{1,0,0,0,0,0, 0,0,0, 0,0,0,            0,1,1, 0,0,0,0};
    vecs[3]  = '{1,1,0,0,5,1, 0,0,0, 0,0,0,            0,1,1, 0,0,0,0};
    vecs[4]  = '{1,1,1,5,6,0, 0,0,0, 0,0,0,            1,1,1, 0,0,0,0};
    vecs[5]  = '{1,1,1,5,6,0, 0,0,0, 1,5,'hDEADBEEF,   1,1,1, 1,5,'hDEADBEEF,0};
    vecs[6]  = '{1,1,1,5,6,0, 0,0,0, 0,0,0,            1,1,1, 0,0,0,0};
    vecs[7]  = '{1,1,1,5,6,0, 0,0,0, 0,0,0,            0,1,1, 0,0,0,0};
    vecs[8]  = '{1,1,0,0,7,1, 0,0,0, 0,0,0,            0,1,1, 0,0,0,0};
    vecs[9]  = '{1,0,0,0,0,0, 1,3,'h11, 1,7,'h77,      0,1,0, 1,3,'h11,0};
    vecs[10] = '{1,0,0,0,0,0, 1,3,'h12, 1,7,'h77,      0,1,0, 1,3,'h12,0};
    vecs[11] = '{1,0,0,0,0,0, 1,3,'h13, 1,7,'h77,      0,1,0, 1,3,'h13,0};
    vecs[12] = '{1,0,0,0,0,0, 1,3,'h14, 1,7,'h77,      0,1,0, 1,3,'h14,0};
    vecs[13] = '{1,0,0,0,0,0, 1,3,'h15, 1,7,'h77,      0,0,1, 1,7,'h77,0};
    vecs[14] = '{1,0,0,0,0,0, 1,3,'h15, 0,0,0,         0,1,0, 1,3,'h15,0};
    vecs[15] = '{1,1,0,0,9,1, 0,0,0, 0,0,0,            0,1,1, 0,0,0,0};
    vecs[16] = '{1,1,0,0,9,0, 0,0,0, 0,0,0,            1,1,1, 0,0,0,0};
    vecs[17] = '{1,1,0,0,0,1, 0,0,0, 0,0,0,            0,1,1, 0,0,0,0};
    vecs[18] = '{1,1,1,0,0,0, 0,0,0, 1,0,'hAB,         0,1,1, 0,0,0,0};
    vecs[19] = '{1,0,0,0,0,0, 0,0,0, 1,9,'h99,         0,1,1, 1,9,'h99,0};
    vecs[20] = '{1,1,0,0,9,0, 0,0,0, 0,0,0,            1,1,1, 0,0,0,0};
    vecs[21] = '{1,1,0,0,9,0, 0,0,0, 0,0,0,            0,1,1, 0,0,0,0};
    vecs[22] = '{1,0,0,0,0,0, 0,0,0, 1,12,'hC0C0,      0,1,1, 1,12,'hC0C0,1};
    vecs[23] = '{1,1,0,0,5,1, 1,2,'h22, 0,0,0,         0,1,0, 1,2,'h22,1};
    vecs[24] = '{0,0,0,0,0,0, 1,2,'h33, 0,0,0,         0,0,0, 0,0,0,0};
    vecs[25] = '{1,1,1,5,1,0, 0,0,0, 0,0,0,            0,1,1, 0,0,0,0};

    apply(vecs[0]);
    @(negedge clk);

    // Directed table: combinational outputs before the edge, registered after it.
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      #1;
      check($sformatf("v%0d iss_stall", i), 32'(iss_stall), 32'(vecs[i].e_stall));
      check($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
      check($sformatf("v%0d lng_ready", i), 32'(lng_ready), 32'(vecs[i].e_lr));
      @(posedge clk);
      #1;
      check($sformatf("v%0d rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we != 0 || vecs[i].rstn == 0) begin
        check($sformatf("v%0d rf_rd", i), 32'(rf_rd), 32'(vecs[i].e_rd));
        check($sformatf("v%0d rf_data", i), rf_data, vecs[i].e_data);
      end
      check($sformatf("v%0d sb_err", i), 32'(sb_err), 32'(vecs[i].e_err));
      @(negedge clk);
    end

    // Starvation: ALU held busy, long x0 result must win on its fifth waiting cycle.
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1;  alu_data = 32'h5A5A;
    lng_valid = 1'b1; lng_rd = 5'd0;  lng_data = 32'h1;
    waited = 0;
    while (waited < 8) begin
      #1;
      if (lng_ready) break;
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    check("starve_wait_cycles", 32'(waited), 32'd4);
    check("starve_alu_blocked", 32'(alu_ready), 32'd0);
    @(posedge clk);
    #1;
    check("starve_x0_no_write", 32'(rf_we), 32'd0);
    @(negedge clk);
    lng_data = 32'h2;
    #1;
    check("starve_cnt_cleared", 32'(lng_ready), 32'd0);
    check("starve_alu_after", 32'(alu_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    alu_valid = 1'b0;
    lng_valid = 1'b0;

    // Randomized traffic against the reference model.
    a_pend = 0; l_pend = 0;
    a_rd = '0; l_rd = '0; a_dat = '0; l_dat = '0;
    for (int c = 0; c < 3000; c++) begin
      bit e_stall, starve, e_ar, e_lr, a_acc, l_acc, err_now;
      rstn = (c == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      if (!a_pend && $urandom_range(0, 1) == 1) begin
        a_pend = 1;
        a_rd   = 5'($urandom_range(0, 31));
        a_dat  = $urandom;
      end
      if (!l_pend && $urandom_range(0, 9) < 4) begin
        l_pend = 1;
        l_rd   = 5'($urandom_range(0, 31));
        for (int t = 0; t < 8; t++) begin
          logic [4:0] cand;
          cand = 5'($urandom_range(1, 7));
          if (m_busy[cand]) begin
            l_rd = cand;
            break;
          end
        end
        l_dat = $urandom;
      end
      alu_valid = a_pend; alu_rd = a_rd; alu_data = a_dat;
      lng_valid = l_pend; lng_rd = l_rd; lng_data = l_dat;
      iss_valid   = 1'($urandom_range(0, 1));
      iss_rs1     = 5'($urandom_range(0, 7));
      iss_rs2     = 5'($urandom_range(0, 7));
      iss_use_rs1 = 1'($urandom_range(0, 1));
      iss_use_rs2 = 1'($urandom_range(0, 1));
      iss_rd      = 5'($urandom_range(0, 7));
      iss_long    = ($urandom_range(0, 9) < 4);
      #1;
      e_stall = iss_valid && ((iss_use_rs1 && m_busy[iss_rs1]) ||
                              (iss_use_rs2 && m_busy[iss_rs2]) ||
                              (iss_rd != 0 && m_busy[iss_rd]));
      starve  = lng_valid && (m_wait >= LIMIT);
      e_lr    = rstn && (!alu_valid || starve);
      e_ar    = rstn && !starve;
      check($sformatf("r%0d iss_stall", c), 32'(iss_stall), 32'(e_stall));
      check($sformatf("r%0d alu_ready", c), 32'(alu_ready), 32'(e_ar));
      check($sformatf("r%0d lng_ready", c), 32'(lng_ready), 32'(e_lr));
      a_acc = alu_valid && e_ar;
      l_acc = lng_valid && e_lr;
      if (!rstn) begin
        foreach (m_busy[k]) m_busy[k] = 0;
        m_wait = 0; m_we = 0; m_tag = 0; m_err = 0; m_rd = '0; m_data = '0;
        a_pend = 0; l_pend = 0;
      end else begin
        err_now = l_acc && (lng_rd != 0) && !m_busy[lng_rd];
        if (m_we && m_tag) m_busy[m_rd] = 0;
        if (iss_valid && !e_stall && iss_long && iss_rd != 0) m_busy[iss_rd] = 1;
        if (err_now) m_err = 1;
        if (l_acc || !lng_valid) m_wait = 0;
        else if (m_wait < 7) m_wait++;
        if (a_acc || l_acc) begin
          m_rd   = l_acc ? lng_rd : alu_rd;
          m_data = l_acc ? lng_data : alu_data;
          m_we   = (m_rd != 0);
          m_tag  = l_acc;
        end else begin
          m_we  = 0;
          m_tag = 0;
        end
        if (a_acc) a_pend = 0;
        if (l_acc) l_pend = 0;
      end
      @(posedge clk);
      #1;
      check($sformatf("r%0d rf_we", c), 32'(rf_we), 32'(m_we));
      if (m_we) begin
        check($sformatf("r%0d rf_rd", c), 32'(rf_rd), 32'(m_rd));
        check($sformatf("r%0d rf_data", c), rf_data, m_data);
      end
      check($sformatf("r%0d sb_err", c), 32'(sb_err), 32'(m_err));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
